// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if
//   Write/commit channel between CPU-side logic and the display scanner.
//   master: drives wr_valid, wr_idx, wr_data, wr_dp, wr_blank and wr_commit;
//           receives wr_ready and commit_ack.
//   slave : the scanner; drives wr_ready and commit_ack.
//   IW must equal $clog2(NDIG) of the attached scanner.
interface seg_scan_driver_if #(
  parameter int IW = 3
);
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_data;
  logic          wr_dp;
  logic          wr_blank;
  logic          wr_commit;
  logic          commit_ack;

  modport master (
    output wr_valid, wr_idx, wr_data, wr_dp, wr_blank, wr_commit,
    input  wr_ready, commit_ack
  );

  modport slave (
    input  wr_valid, wr_idx, wr_data, wr_dp, wr_blank, wr_commit,
    output wr_ready, commit_ack
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Drives an NDIG-digit multiplexed 7-segment panel. Digit values are written
//   into a shadow buffer; a commit copies shadow->active on the last cycle of a
//   frame so the panel never shows a half-updated image. Each digit slot lasts
//   SCAN_DIV cycles, the first BLANK of which keep the panel dark to stop
//   ghosting between digits.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   wr         : write/commit channel (slave side)
//   frame_done : 1-cycle pulse on the first cycle of every frame
//   seg_n      : active-low segments, bit0=a .. bit6=g, bit7=dp
//   dig_sel_n  : active-low one-hot digit select
module seg_scan_driver #(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_driver_if.slave    wr,
  output logic                frame_done,
  output logic [7:0]          seg_n,
  output logic [NDIG-1:0]     dig_sel_n
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef struct packed {
    logic [3:0] data;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam digit_t DIGIT_RST = '{data: 4'h0, dp: 1'b0, blank: 1'b1};

  // Slot phase is a pure decode of the slot counter, so it needs no register.
  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_phase_e;

  // Active-low a..g pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            commit_ack_q, commit_ack_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      seg_n_q, seg_n_d;
  logic [NDIG-1:0] dig_sel_n_q, dig_sel_n_d;
  digit_t          shadow_q [NDIG];
  digit_t          shadow_d [NDIG];
  digit_t          active_q [NDIG];
  digit_t          active_d [NDIG];

  logic            ready;
  logic            last_slot_cycle;
  logic            frame_end;
  logic            wr_fire;
  slot_phase_e     phase;
  digit_t          cur;

  // A pending commit blocks the channel until it has been applied.
  assign ready         = ~pending_q;
  assign wr.wr_ready   = ready;
  assign wr.commit_ack = commit_ack_q;
  assign frame_done    = frame_done_q;
  assign seg_n         = seg_n_q;
  assign dig_sel_n     = dig_sel_n_q;

  always_comb begin
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    seg_n_d      = 8'hFF;
    dig_sel_n_d  = '1;

    // Scan timing: slot counter, then digit pointer.
    last_slot_cycle = (int'(cnt_q) == SCAN_DIV - 1);
    frame_end       = last_slot_cycle && (int'(ptr_q) == NDIG - 1);
    if (last_slot_cycle) begin
      cnt_d = '0;
      ptr_d = frame_end ? '0 : ptr_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Shadow writes; an out-of-range index is accepted but dropped.
    wr_fire = wr.wr_valid & ready;
    if (wr_fire && (int'(wr.wr_idx) < NDIG)) begin
      shadow_d[wr.wr_idx] = '{data: wr.wr_data, dp: wr.wr_dp, blank: wr.wr_blank};
    end

    // Apply and accept are exclusive: accepting needs ready, i.e. nothing pending.
    // The copy reads shadow_q, so a same-cycle write is already in the shadow
    // by the time any commit it accompanied gets applied.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (wr.wr_commit && ready) begin
      pending_d = 1'b1;
    end

    commit_ack_d = frame_end & pending_q;
    frame_done_d = frame_end;

    // Output decode for the current slot position.
    phase = (int'(cnt_q) < BLANK) ? SLOT_BLANK : SLOT_SHOW;
    cur   = active_q[ptr_q];
    if ((phase == SLOT_SHOW) && !cur.blank) begin
      seg_n_d     = {~cur.dp, hex_to_seg(cur.data)};
      dig_sel_n_d = ~(NDIG'(1) << ptr_q);
    end
  end

  // ---- register stage: timing, buffers, registered panel outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      commit_ack_q <= 1'b0;
      frame_done_q <= 1'b0;
      seg_n_q      <= 8'hFF;
      dig_sel_n_q  <= '1;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i] <= DIGIT_RST;
        active_q[i] <= DIGIT_RST;
      end
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      commit_ack_q <= commit_ack_d;
      frame_done_q <= frame_done_d;
      seg_n_q      <= seg_n_d;
      dig_sel_n_q  <= dig_sel_n_d;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

endmodule
